fib_stream_check: RTL

FIB_STREAM_CHECK -- requirements
Module: fib_stream_check

---
 rtl/fib_pkg.sv | 15 +
 rtl/fib_term_fifo.sv | 69 ++++++
 rtl/fib_stream_check.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/fib_pkg.sv
// Shared types for the Fibonacci stream checker: FSM states, term type and default FIFO depth.
package fib_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    CHECK = 2'd2,
    FAULT = 2'd3
  } fib_state_t;

  typedef logic [7:0] term_t;

  localparam int DEFAULT_DEPTH = 4;

endpackage

// File: rtl/fib_term_fifo.sv
// Small valid/ready FIFO for checked terms; head is read combinationally so a pushed term
// is visible one cycle after acceptance. clr flushes and overrides any same-cycle push/pop.
module fib_term_fifo
  import fib_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  clr,
  input  logic  push_valid,
  output logic  push_ready,
  input  term_t push_data,
  output logic  pop_valid,
  input  logic  pop_ready,
  output term_t pop_data
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  term_t         mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [AW:0]   count_reg;
  logic          full;
  logic          empty;
  logic          do_push;
  logic          do_pop;

  assign full       = (count_reg == (AW+1)'(DEPTH));
  assign empty      = (count_reg == '0);
  // No pass-through: a full FIFO refuses a push even if the head is leaving this cycle.
  assign push_ready = ~full;
  assign pop_valid  = ~empty;
  assign pop_data   = mem[rd_ptr_reg];
  assign do_push    = push_valid & push_ready & ~clr;
  assign do_pop     = pop_valid & pop_ready & ~clr;

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (clr) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      end
      if (do_pop) begin
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + (AW+1)'(1);
        2'b01:   count_reg <= count_reg - (AW+1)'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/fib_stream_check.sv
// Checks an 8-bit term stream against the Fibonacci recurrence and queues conforming terms.
// Optional running sum of enqueued terms is enabled with macro FIB_STREAM_CHECK_SUM_EN.
module fib_stream_check
  import fib_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_adv,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  input  logic        clr,
  output logic        out_valid,
  output logic [7:0]  out_data,
  input  logic        out_ready,
  output logic        err,
  output logic [15:0] term_cnt
`ifdef FIB_STREAM_CHECK_SUM_EN
  ,
  output logic [15:0] sum_out
`endif
);

  fib_state_t  state_reg;
  fib_state_t  state_next;
  term_t       prev1_reg;
  term_t       prev2_reg;
  logic        err_reg;
  logic [15:0] term_cnt_reg;
  logic        fifo_push_ready;
  logic        accept;
  logic        enq;
  logic        set_err;
  logic        match;
  term_t       expected_term;

  assign in_ready      = (state_reg == FAULT) ? 1'b1 : fifo_push_ready;
  assign accept        = in_adv & in_ready;
  assign expected_term = prev2_reg + prev1_reg;
  assign match         = (in_data == expected_term);
  assign err           = err_reg;
  assign term_cnt      = term_cnt_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    enq        = 1'b0;
    set_err    = 1'b0;
    if (clr) begin
      state_next = IDLE;
    end else if (accept) begin
      case (state_reg)
        IDLE: begin
          enq        = 1'b1;
          state_next = PRIME;
        end
        PRIME: begin
          enq        = 1'b1;
          state_next = CHECK;
        end
        CHECK: begin
          if (match) begin
            enq = 1'b1;
          end else begin
            set_err    = 1'b1;
            state_next = FAULT;
          end
        end
        default: ;  // FAULT swallows terms until clr/rst
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev1_reg    <= '0;
      prev2_reg    <= '0;
      err_reg      <= 1'b0;
      term_cnt_reg <= '0;
    end else if (clr) begin
      prev1_reg    <= '0;
      prev2_reg    <= '0;
      err_reg      <= 1'b0;
      term_cnt_reg <= '0;
    end else begin
      if (set_err) begin
        err_reg <= 1'b1;
      end
      if (accept && (term_cnt_reg != 16'hFFFF)) begin
        term_cnt_reg <= term_cnt_reg + 16'd1;
      end
      if (accept) begin
        case (state_reg)
          IDLE:  prev2_reg <= in_data;
          PRIME: prev1_reg <= in_data;
          CHECK: begin
            if (match) begin
              prev2_reg <= prev1_reg;
              prev1_reg <= in_data;
            end
          end
          default: ;
        endcase
      end
    end
  end

`ifdef FIB_STREAM_CHECK_SUM_EN
  logic [15:0] sum_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_reg <= '0;
    end else if (clr) begin
      sum_reg <= '0;
    end else if (enq) begin
      sum_reg <= sum_reg + {8'd0, in_data};
    end
  end

  assign sum_out = sum_reg;
`else
  // default build carries no running sum
`endif

  fib_term_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .clr       (clr),
    .push_valid(enq),
    .push_ready(fifo_push_ready),
    .push_data (in_data),
    .pop_valid (out_valid),
    .pop_ready (out_ready),
    .pop_data  (out_data)
  );

endmodule
